mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_pkg.sv | 27 ++
 rtl/mem_align_chk.sv | 27 ++
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// ============================================================================
// mem_pkg -- shared encodings for the instruction/data memory arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_e;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } owner_e;

endpackage : mem_pkg

`default_nettype wire

// File: rtl/mem_align_chk.sv
// ============================================================================
// mem_align_chk -- flags an access whose address does not suit its size
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_align_chk
  import mem_pkg::*;
(
  input  logic [1:0] addr,
  input  logic [1:0] size,
  output logic       misaligned
);

  always_comb begin
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = addr[0];
      SZ_WORD: misaligned = |addr;
      default: misaligned = 1'b1;
    endcase
  end

endmodule : mem_align_chk

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter -- shares one memory between fetch and data ports, data first
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_size,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write,
  output logic        mem_read,
  output logic [1:0]  mem_size,
  input  logic [31:0] mem_read_data
);

  localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;

  logic w_if_mis;
  logic w_d_mis;
  logic w_fetch_win;
  logic w_sel_mis;

  mem_align_chk u_if_chk (
    .addr       (if_addr[1:0]),
    .size       (SZ_WORD),
    .misaligned (w_if_mis)
  );

  mem_align_chk u_d_chk (
    .addr       (d_addr[1:0]),
    .size       (d_size),
    .misaligned (w_d_mis)
  );

  // Fetch only beats a pending data request once it has lost STARVE_LIMIT times in a row.
  assign w_fetch_win = if_req && (!d_req || (starve_cnt_q == LIMIT_C));
  assign w_sel_mis   = w_fetch_win ? w_if_mis : w_d_mis;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= FETCH;
      starve_cnt_q <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= '0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      size_q       <= size_d;
      we_q         <= we_d;
      err_q        <= err_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    starve_cnt_d = starve_cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    size_d       = size_q;
    we_d         = we_q;
    err_d        = err_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          owner_d = w_fetch_win ? FETCH : DATA;
          err_d   = w_sel_mis;
          if (w_fetch_win) begin
            starve_cnt_d = '0;
          end else if (if_req && (starve_cnt_q != LIMIT_C)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
          end
          // Misaligned requests never reach memory, so the mem_* bus keeps its old values.
          if (w_sel_mis) begin
            state_d = RESP;
            if (w_fetch_win) if_rdata_d = '0;
            else             d_rdata_d  = '0;
          end else begin
            state_d = ACCESS;
            addr_d  = w_fetch_win ? if_addr : d_addr;
            size_d  = w_fetch_win ? SZ_WORD : d_size;
            we_d    = !w_fetch_win && d_we;
            if (!w_fetch_win) wdata_d = d_wdata;
          end
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (owner_q == FETCH) if_rdata_d = mem_read_data;
        else                  d_rdata_d  = we_q ? 32'h0 : mem_read_data;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  assign mem_size       = size_q;
  assign mem_write      = (state_q == ACCESS) && we_q;
  assign mem_read       = (state_q == ACCESS) && !we_q;

  assign if_ready = (state_q == RESP) && (owner_q == FETCH);
  assign d_ready  = (state_q == RESP) && (owner_q == DATA);
  assign if_err   = if_ready && err_q;
  assign d_err    = d_ready && err_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule : mem_arbiter

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter -- directed self-checking bench with a byte-addressed memory
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [1:0]  d_size = '0;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [1:0]  mem_size;
  logic [31:0] mem_read_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .if_ready       (if_ready),
    .if_rdata       (if_rdata),
    .if_err         (if_err),
    .d_req          (d_req),
    .d_we           (d_we),
    .d_addr         (d_addr),
    .d_wdata        (d_wdata),
    .d_size         (d_size),
    .d_ready        (d_ready),
    .d_rdata        (d_rdata),
    .d_err          (d_err),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .mem_read       (mem_read),
    .mem_size       (mem_size),
    .mem_read_data  (mem_read_data)
  );

  // Little-endian memory with combinational, sign-extended reads.
  logic [7:0] mem [0:63] = '{default: 8'h00};
  logic [5:0] ma;

  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_address[5:0]] <= mem_write_data[7:0];
      if (mem_size != SZ_BYTE) mem[mem_address[5:0] + 6'd1] <= mem_write_data[15:8];
      if (mem_size == SZ_WORD) begin
        mem[mem_address[5:0] + 6'd2] <= mem_write_data[23:16];
        mem[mem_address[5:0] + 6'd3] <= mem_write_data[31:24];
      end
    end
  end

  always_comb begin
    ma = mem_address[5:0];
    case (mem_size)
      SZ_BYTE: mem_read_data = {{24{mem[ma][7]}}, mem[ma]};
      SZ_HALF: mem_read_data = {{16{mem[ma + 6'd1][7]}}, mem[ma + 6'd1], mem[ma]};
      default: mem_read_data = {mem[ma + 6'd3], mem[ma + 6'd2], mem[ma + 6'd1], mem[ma]};
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request at a negedge and follow it to its ready pulse.
  task automatic xfer(input string tag, input bit fetch, input logic we,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [1:0] size, input int exp_lat,
                      input logic [31:0] exp_rdata, input logic exp_err);
    int          cyc;
    logic        rdy;
    logic        both;
    logic [1:0]  acc_rw;
    logic [1:0]  exp_rw;
    logic [31:0] acc_addr;
    if (fetch) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_size = size;
    end
    cyc = 0; rdy = 1'b0; both = 1'b0; acc_rw = '0; acc_addr = '0;
    while (!rdy && cyc < 8) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        acc_rw   = {mem_write, mem_read};
        acc_addr = mem_address;
      end
      both = both | (if_ready & d_ready);
      rdy  = fetch ? if_ready : d_ready;
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    exp_rw = exp_err ? 2'b00 : ((we && !fetch) ? 2'b10 : 2'b01);
    check({tag, " latency"}, cyc, exp_lat);
    check({tag, " mem rw"}, {30'd0, acc_rw}, {30'd0, exp_rw});
    if (!exp_err) check({tag, " mem addr"}, acc_addr, addr);
    check({tag, " rdata"}, fetch ? if_rdata : d_rdata, exp_rdata);
    check({tag, " err"}, {31'd0, fetch ? if_err : d_err}, {31'd0, exp_err});
    check({tag, " one ready"}, {31'd0, both}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          d_at, i_at, nd;
    logic        both, seen;
    logic [31:0] st_mid;

    repeat (2) @(negedge clk);
    check("rst ready", {30'd0, if_ready, d_ready}, 32'd0);
    check("rst mem rw", {30'd0, mem_read, mem_write}, 32'd0);
    check("rst mem addr", mem_address, 32'd0);
    check("rst rdata", d_rdata | if_rdata, 32'd0);
    check("rst size err", {29'd0, mem_size, if_err | d_err}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    xfer("st_w",  1'b0, 1'b1, 32'h00, 32'h12345678, SZ_WORD, 2, 32'h0, 1'b0);
    xfer("ld_w",  1'b0, 1'b0, 32'h00, 32'h0,        SZ_WORD, 2, 32'h12345678, 1'b0);
    xfer("st_b",  1'b0, 1'b1, 32'h08, 32'h000000FF, SZ_BYTE, 2, 32'h0, 1'b0);
    xfer("ld_b",  1'b0, 1'b0, 32'h08, 32'h0,        SZ_BYTE, 2, 32'hFFFFFFFF, 1'b0);
    check("hold rdata", d_rdata, 32'hFFFFFFFF);
    check("hold mem addr", mem_address, 32'h08);
    check("hold mem rw", {30'd0, mem_read, mem_write}, 32'd0);
    xfer("ld_h0", 1'b0, 1'b0, 32'h00, 32'h0,        SZ_HALF, 2, 32'h00005678, 1'b0);
    xfer("ld_h13",1'b0, 1'b0, 32'h13, 32'h0,        SZ_HALF, 1, 32'h0, 1'b1);
    xfer("ld_ill",1'b0, 1'b0, 32'h00, 32'h0,        SZ_ILLEGAL, 1, 32'h0, 1'b1);
    xfer("if_02", 1'b1, 1'b0, 32'h02, 32'h0,        SZ_WORD, 1, 32'h0, 1'b1);
    xfer("if_00", 1'b1, 1'b0, 32'h00, 32'h0,        SZ_WORD, 2, 32'h12345678, 1'b0);

    // Request withdrawn right after it was sampled.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h00; d_size = SZ_WORD;
    @(posedge clk); @(negedge clk);
    d_req = 1'b0;
    @(posedge clk); @(negedge clk);
    check("drop ready", {31'd0, d_ready}, 32'd1);
    check("drop rdata", d_rdata, 32'h12345678);
    @(negedge clk);

    // Simultaneous requests: data first, fetch in the next arbitration.
    check("starve pre", 32'(dut.starve_cnt_q), 32'd0);
    if_req = 1'b1; if_addr = 32'h00;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h08; d_size = SZ_BYTE;
    d_at = 0; i_at = 0; both = 1'b0;
    for (int c = 1; c <= 12 && i_at == 0; c++) begin
      @(posedge clk); @(negedge clk);
      both = both | (if_ready & d_ready);
      if (d_ready && d_at == 0) begin
        d_at = c; d_req = 1'b0;
        check("sim d_rdata", d_rdata, 32'hFFFFFFFF);
      end
      if (if_ready) begin
        i_at = c; if_req = 1'b0;
        check("sim if_rdata", if_rdata, 32'h12345678);
      end
    end
    check("sim d_ready cycle", d_at, 32'd2);
    check("sim if_ready cycle", i_at, 32'd5);
    check("sim one ready", {31'd0, both}, 32'd0);
    @(negedge clk);

    // Both held: four data grants, then fetch forced through.
    if_req = 1'b1; if_addr = 32'h00;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h00; d_size = SZ_WORD;
    nd = 0; i_at = 0; st_mid = '0;
    for (int c = 1; c <= 20 && i_at == 0; c++) begin
      @(posedge clk); @(negedge clk);
      if (d_ready) nd++;
      if (c == 12) st_mid = 32'(dut.starve_cnt_q);
      if (if_ready) begin
        i_at = c; if_req = 1'b0; d_req = 1'b0;
      end
    end
    check("starve data grants", nd, 32'd4);
    check("starve if_ready cycle", i_at, 32'd14);
    check("starve cnt saturated", st_mid, 32'd4);
    check("starve cnt cleared", 32'(dut.starve_cnt_q), 32'd0);
    @(negedge clk);

    // Reset in the middle of a store access.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEADBEEF; d_size = SZ_WORD;
    @(posedge clk); @(negedge clk);
    check("rst acc mem_write before", {31'd0, mem_write}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("rst acc mem_write after", {31'd0, mem_write}, 32'd0);
    check("rst acc state", 32'(dut.state_q), 32'(IDLE));
    check("rst acc mem addr", mem_address, 32'd0);
    d_req = 1'b0;
    #1 reset = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); @(negedge clk);
      seen = seen | d_ready;
    end
    check("rst acc no ready", {31'd0, seen}, 32'd0);
    xfer("ld_10",  1'b0, 1'b0, 32'h10, 32'h0,        SZ_WORD, 2, 32'h0, 1'b0);
    xfer("st_10",  1'b0, 1'b1, 32'h10, 32'hCAFEF00D, SZ_WORD, 2, 32'h0, 1'b0);
    xfer("ld_10b", 1'b0, 1'b0, 32'h10, 32'h0,        SZ_WORD, 2, 32'hCAFEF00D, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_mem_arbiter

`default_nettype wire
